channel_layout_tracker: RTL and testbench

- Sequential, parametrised successor to the combinational pixel-row-to-channel mapper in the trace display path.
- On each frame start it latches the channel enables, counts enabled channels, computes an exact channel height by iterative restoring division, and builds a visible-to-physical channel map table.
- It then follows the scanned row with incremental counters, giving registered per-row channel number, offset, height and row-within-channel to the trace renderer.
- It has no per-row dividers, no multiplier approximation, and no wide combinational loops.

---
 rtl/channel_layout_tracker.sv | 208 ++++++++++++++++++++
 tb/tb_channel_layout_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/channel_layout_tracker.sv
// Per-frame channel layout engine for the trace display: latches enables, divides the
// visible span by the enabled-channel count, builds a visible-to-physical map, then tracks rows.
module channel_layout_tracker #(
    parameter int MAX_CHAN_COUNT = 10,
    parameter int VER_RES        = 480,
    parameter int OFFSET         = 0,
    parameter int ROW_W          = $clog2(VER_RES),
    parameter int CH_W           = $clog2(MAX_CHAN_COUNT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
    input  logic                      frame_start,
    input  logic                      row_advance,
    output logic                      busy,
    output logic                      layout_valid,
    output logic                      overrun,
    output logic [CH_W-1:0]           channel_count,
    output logic                      is_channel,
    output logic [CH_W-1:0]           channel_number,
    output logic [ROW_W-1:0]          channel_height,
    output logic [ROW_W-1:0]          channel_offset,
    output logic [ROW_W-1:0]          row_in_channel
);

    localparam int IDX_W    = (MAX_CHAN_COUNT > 1) ? $clog2(MAX_CHAN_COUNT) : 1;
    localparam int STEP_MAX = (ROW_W > MAX_CHAN_COUNT) ? ROW_W : MAX_CHAN_COUNT;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    localparam logic [ROW_W-1:0]  SPAN      = ROW_W'(VER_RES - OFFSET);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(VER_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(OFFSET);
    localparam logic [ROW_W:0]    OFFSET_X  = (ROW_W + 1)'(OFFSET);
    localparam logic [STEP_W-1:0] DIV_LAST  = STEP_W'(ROW_W - 1);
    localparam logic [STEP_W-1:0] MAP_LAST  = STEP_W'(MAX_CHAN_COUNT - 1);

    typedef enum logic [2:0] {IDLE, COUNT, DIVIDE, MAP, READY} state_t;

    state_t                    state_q, state_d;
    logic [STEP_W-1:0]         step_q;
    logic                      enter_ready;

    logic [MAX_CHAN_COUNT-1:0] shadow_q;
    logic [CH_W-1:0]           count_q;
    logic [CH_W-1:0]           pop_c;
    logic [ROW_W-1:0]          height_q;
    logic [ROW_W-1:0]          div_quot_q;
    logic [CH_W-1:0]           div_rem_q;
    logic [CH_W:0]             rem_shift_c;
    logic [CH_W+1:0]           diff_c;
    logic                      fits_c;
    logic [CH_W-1:0]           map_q [MAX_CHAN_COUNT];
    logic [CH_W-1:0]           map_n_q;

    logic [ROW_W-1:0]          row_q;
    logic [CH_W-1:0]           vis_q;
    logic [ROW_W-1:0]          ric_q;
    logic [ROW_W-1:0]          offset_q;
    logic                      valid_q;
    logic                      overrun_q;
    logic                      row_ge_offset;

    // ---------------- FSM ----------------
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = COUNT;
        end else begin
            case (state_q)
                COUNT:   state_d = DIVIDE;
                DIVIDE:  if (step_q == DIV_LAST) state_d = MAP;
                MAP:     if (step_q == MAP_LAST) state_d = READY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy        = 1'b0;
        enter_ready = 1'b0;
        case (state_q)
            COUNT, DIVIDE: busy = 1'b1;
            MAP: begin
                busy        = 1'b1;
                enter_ready = (state_d == READY);
            end
            default: ;
        endcase
    end

    // Step counter restarts on every state change and only runs while computing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   step_q <= '0;
        else if (state_d != state_q) step_q <= '0;
        else if (busy)               step_q <= step_q + STEP_W'(1);
    end

    // ---------------- layout computation ----------------
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < MAX_CHAN_COUNT; i++) pop_c = pop_c + CH_W'(shadow_q[i]);
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift_c = {div_rem_q, div_quot_q[ROW_W-1]};
    assign diff_c      = {1'b0, rem_shift_c} - {2'b00, count_q};
    assign fits_c      = ~diff_c[CH_W+1];

    // NOTE: the map table sits in the reset branch so no stale layout survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q   <= '0;
            count_q    <= '0;
            height_q   <= '0;
            div_quot_q <= '0;
            div_rem_q  <= '0;
            map_n_q    <= '0;
            for (int i = 0; i < MAX_CHAN_COUNT; i++) map_q[i] <= '0;
        end else begin
            if (frame_start) shadow_q <= channel_enable;
            case (state_q)
                COUNT: begin
                    count_q    <= pop_c;
                    div_quot_q <= SPAN;
                    div_rem_q  <= '0;
                    map_n_q    <= '0;
                end
                DIVIDE: begin
                    if (fits_c) begin
                        div_rem_q  <= diff_c[CH_W-1:0];
                        div_quot_q <= {div_quot_q[ROW_W-2:0], 1'b1};
                    end else begin
                        div_rem_q  <= rem_shift_c[CH_W-1:0];
                        div_quot_q <= {div_quot_q[ROW_W-2:0], 1'b0};
                    end
                end
                MAP: begin
                    // A zero divisor yields an all-ones quotient; height is defined as 0 there.
                    if (step_q == '0) height_q <= (count_q == '0) ? '0 : div_quot_q;
                    if (shadow_q[step_q[IDX_W-1:0]]) begin
                        map_q[map_n_q[IDX_W-1:0]] <= CH_W'(step_q);
                        map_n_q                   <= map_n_q + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- row tracking ----------------
    assign row_ge_offset = ({1'b0, row_q} + (ROW_W + 1)'(1)) > OFFSET_X;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q     <= '0;
            vis_q     <= '0;
            ric_q     <= '0;
            offset_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (frame_start) begin
            row_q     <= '0;
            vis_q     <= '0;
            ric_q     <= '0;
            offset_q  <= ROW_FIRST;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (enter_ready) begin
                valid_q  <= 1'b1;
                vis_q    <= '0;
                ric_q    <= '0;
                offset_q <= ROW_FIRST;
            end
            if (row_advance) begin
                if (row_q != ROW_LAST) row_q <= row_q + ROW_W'(1);
                if (busy) overrun_q <= 1'b1;
                // Header rows and the saturated last row leave the channel position untouched.
                if (state_q == READY && row_q != ROW_LAST && row_ge_offset && count_q != '0) begin
                    if (ric_q == height_q - ROW_W'(1)) begin
                        if (vis_q != count_q) vis_q <= vis_q + CH_W'(1);
                        ric_q    <= '0;
                        offset_q <= offset_q + height_q;
                    end else begin
                        ric_q <= ric_q + ROW_W'(1);
                    end
                end
            end
        end
    end

    assign is_channel     = valid_q & ~overrun_q & row_ge_offset & (count_q != '0) & (vis_q < count_q);
    assign channel_number = is_channel ? map_q[vis_q[IDX_W-1:0]] : '0;
    assign layout_valid   = valid_q;
    assign overrun        = overrun_q;
    assign channel_count  = count_q;
    assign channel_height = height_q;
    assign channel_offset = offset_q;
    assign row_in_channel = ric_q;

endmodule

// File: tb/tb_channel_layout_tracker.sv
// Directed bench for channel_layout_tracker: a default instance and an OFFSET=32 instance
// share stimulus; expected values are hand-computed.
module tb_channel_layout_tracker;

    logic       clk;
    logic       rst;
    logic [9:0] channel_enable;
    logic       frame_start;
    logic       row_advance;

    logic       a_busy, a_valid, a_overrun, a_is_ch;
    logic [3:0] a_count, a_number;
    logic [8:0] a_height, a_offset, a_ric;

    logic       b_busy, b_valid, b_overrun, b_is_ch;
    logic [3:0] b_count, b_number;
    logic [8:0] b_height, b_offset, b_ric;

    int n_checks = 0;
    int n_fail   = 0;

    channel_layout_tracker dut_a (
        .clk(clk), .reset(rst), .channel_enable(channel_enable),
        .frame_start(frame_start), .row_advance(row_advance),
        .busy(a_busy), .layout_valid(a_valid), .overrun(a_overrun),
        .channel_count(a_count), .is_channel(a_is_ch), .channel_number(a_number),
        .channel_height(a_height), .channel_offset(a_offset), .row_in_channel(a_ric)
    );

    channel_layout_tracker #(.OFFSET(32)) dut_b (
        .clk(clk), .reset(rst), .channel_enable(channel_enable),
        .frame_start(frame_start), .row_advance(row_advance),
        .busy(b_busy), .layout_valid(b_valid), .overrun(b_overrun),
        .channel_count(b_count), .is_channel(b_is_ch), .channel_number(b_number),
        .channel_height(b_height), .channel_offset(b_offset), .row_in_channel(b_ric)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            row_advance = 1'b1;
            tick();
            row_advance = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [9:0] en, input string tag);
        int cycles;
        channel_enable = en;
        frame_start    = 1'b1;
        tick();
        frame_start = 1'b0;
        cycles      = 0;
        while (a_busy && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, "_busy_cycles"}, cycles, 20);
        check({tag, "_layout_valid"}, a_valid, 1);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_overrun"}, a_overrun, 0);
        check({tag, "_count"}, a_count, 0);
        check({tag, "_is_ch"}, a_is_ch, 0);
        check({tag, "_number"}, a_number, 0);
        check({tag, "_height"}, a_height, 0);
        check({tag, "_offset"}, a_offset, 0);
        check({tag, "_ric"}, a_ric, 0);
    endtask

    initial begin
        rst            = 1'b1;
        channel_enable = '0;
        frame_start    = 1'b0;
        row_advance    = 1'b0;
        tick();
        tick();
        check_a_zero("reset");
        check("reset_b_height", b_height, 0);
        rst = 1'b0;
        tick();

        // Three channels 0,2,5: height 480/3 = 160; B spans 448 -> 149.
        run_frame(10'b0000100101, "f3");
        check("f3_count", a_count, 3);
        check("f3_height", a_height, 160);
        check("f3_b_height", b_height, 149);
        check("f3_r0_is_ch", a_is_ch, 1);
        check("f3_r0_number", a_number, 0);
        check("f3_r0_offset", a_offset, 0);
        advance(160);
        check("f3_r160_number", a_number, 2);
        check("f3_r160_offset", a_offset, 160);
        check("f3_r160_ric", a_ric, 0);
        advance(319);
        check("f3_r479_number", a_number, 5);
        check("f3_r479_ric", a_ric, 159);
        advance(1);
        check("f3_sat_ric", a_ric, 159);
        check("f3_sat_is_ch", a_is_ch, 1);

        // Seven channels: 480/7 = 68, rows 476..479 are remainder; B: 448/7 = 64.
        run_frame(10'b0001111111, "f7");
        check("f7_count", a_count, 7);
        check("f7_height", a_height, 68);
        check("f7_b_height", b_height, 64);
        advance(475);
        check("f7_r475_is_ch", a_is_ch, 1);
        check("f7_r475_number", a_number, 6);
        check("f7_r475_ric", a_ric, 67);
        check("f7_b_r475_number", b_number, 6);
        check("f7_b_r475_ric", b_ric, 59);
        advance(1);
        check("f7_r476_is_ch", a_is_ch, 0);
        check("f7_r476_number", a_number, 0);
        advance(3);
        check("f7_r479_is_ch", a_is_ch, 0);

        // Channels 1 and 3; B header rows 0..31, height 224; A height 240.
        run_frame(10'b0000001010, "f2");
        check("f2_b_height", b_height, 224);
        check("f2_a_height", a_height, 240);
        check("f2_b_r0_is_ch", b_is_ch, 0);
        advance(31);
        check("f2_b_r31_is_ch", b_is_ch, 0);
        advance(1);
        check("f2_b_r32_is_ch", b_is_ch, 1);
        check("f2_b_r32_number", b_number, 1);
        check("f2_b_r32_offset", b_offset, 32);
        check("f2_b_r32_ric", b_ric, 0);
        advance(224);
        check("f2_b_r256_number", b_number, 3);
        check("f2_b_r256_offset", b_offset, 256);
        check("f2_b_r256_ric", b_ric, 0);
        check("f2_a_r256_number", a_number, 3);
        check("f2_a_r256_ric", a_ric, 16);

        // No channels, then enables change mid-frame without effect.
        run_frame(10'b0000000000, "f0");
        check("f0_count", a_count, 0);
        check("f0_height", a_height, 0);
        check("f0_r0_is_ch", a_is_ch, 0);
        channel_enable = 10'b1111111111;
        advance(100);
        check("f0_r100_is_ch", a_is_ch, 0);
        check("f0_r100_count", a_count, 0);
        run_frame(10'b1111111111, "f10");
        check("f10_count", a_count, 10);
        check("f10_height", a_height, 48);
        check("f10_r0_is_ch", a_is_ch, 1);
        advance(479);
        check("f10_r479_number", a_number, 9);
        check("f10_r479_ric", a_ric, 47);
        check("f10_r479_offset", a_offset, 432);

        // row_advance on busy cycle 5 -> overrun for the rest of the frame.
        channel_enable = 10'b1000000001;
        frame_start    = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        row_advance = 1'b1;
        tick();
        row_advance = 1'b0;
        check("ov_overrun_set", a_overrun, 1);
        for (int i = 0; i < 100 && a_busy; i++) tick();
        check("ov_valid", a_valid, 1);
        check("ov_is_ch", a_is_ch, 0);
        advance(10);
        check("ov_sticky", a_overrun, 1);
        check("ov_is_ch_later", a_is_ch, 0);
        run_frame(10'b1000000001, "ovr");
        check("ovr_overrun_clear", a_overrun, 0);
        check("ovr_r0_is_ch", a_is_ch, 1);
        advance(240);
        check("ovr_r240_number", a_number, 9);

        // Reset mid-frame at row 300.
        run_frame(10'b0000000011, "rs");
        advance(300);
        check("rs_r300_number", a_number, 1);
        check("rs_r300_ric", a_ric, 60);
        rst = 1'b1;
        #1;
        check_a_zero("rs_row300");
        tick();
        rst = 1'b0;
        tick();

        // Reset during DIVIDE.
        channel_enable = 10'b0000001111;
        frame_start    = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        check("rd_busy_before", a_busy, 1);
        rst = 1'b1;
        #1;
        check_a_zero("rd_divide");
        tick();
        rst = 1'b0;
        tick();
        run_frame(10'b0000000110, "post");
        check("post_count", a_count, 2);
        check("post_height", a_height, 240);
        check("post_r0_number", a_number, 1);
        advance(240);
        check("post_r240_number", a_number, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
